// File: rtl/dma_apb_mem_slave_if.sv
// APB bus bundle between a DMA APB initiator and a dma_apb_mem_slave completer.
// Signal names carry the completer's direction prefix (i_ = into the slave, o_ = out of it).
interface dma_apb_mem_slave_if #(
    parameter int APB_ADDR_WIDTH = 16,
    parameter int APB_DATA_WIDTH = 16
);
    logic                      i_psel;
    logic                      i_penable;
    logic                      i_pwrite;
    logic [APB_ADDR_WIDTH-1:0] i_paddr;
    logic [APB_DATA_WIDTH-1:0] i_pwdata;
    logic                      o_pready;
    logic [APB_DATA_WIDTH-1:0] o_prdata;
    logic                      o_pslverr;

    modport master (
        output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
        input  o_pready, o_prdata, o_pslverr
    );

    modport slave (
        input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
        output o_pready, o_prdata, o_pslverr
    );
endinterface

// File: rtl/dma_apb_mem_slave.sv
// APB completer backed by a word-addressed memory, inserting WAIT_STATES wait cycles per access.
// Optional: define DMA_APB_SLV_PSLVERR_EN to report out-of-range transfers on o_pslverr.
module dma_apb_mem_slave #(
    parameter int APB_ADDR_WIDTH = 16,
    parameter int APB_DATA_WIDTH = 16,
    parameter int MEM_DEPTH      = 64,
    parameter int BASE_ADDR      = 0,
    parameter int WAIT_STATES    = 1
) (
    input logic                pclk,
    input logic                pnreset,
    dma_apb_mem_slave_if.slave bus
);
    localparam int AW = APB_ADDR_WIDTH;
    localparam int DW = APB_DATA_WIDTH;
    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [AW:0] BASE_EXT  = (AW+1)'(BASE_ADDR);
    localparam logic [AW:0] DEPTH_EXT = (AW+1)'(MEM_DEPTH);
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          r_state;
    state_t          w_phase;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_nxt;
    logic [AW-1:0]   r_addr;
    logic            r_write;
    logic [DW-1:0]   r_wdata;
    logic            r_pready;
    logic [DW-1:0]   r_prdata;
    logic [DW-1:0]   r_mem [MEM_DEPTH];

    logic [AW-1:0]   w_addr_sel;
    logic            w_write_sel;
    logic [AW:0]     w_idx_ext;
    logic [IW-1:0]   w_idx;
    logic            w_in_range;
    logic            w_load;
    logic            w_ready_set;
    logic            w_do_write;
    logic [DW-1:0]   w_prdata_nxt;

    // The setup phase is decoded from the live bus so pready can rise in the first access cycle.
    always_comb begin
        w_phase = r_state;
        if (r_state == IDLE && bus.i_psel && !bus.i_penable) begin
            w_phase = SETUP;
        end
        w_addr_sel  = (w_phase == SETUP) ? bus.i_paddr  : r_addr;
        w_write_sel = (w_phase == SETUP) ? bus.i_pwrite : r_write;
        w_idx_ext   = {1'b0, w_addr_sel} - BASE_EXT;
        w_in_range  = ({1'b0, w_addr_sel} >= BASE_EXT) && (w_idx_ext < DEPTH_EXT);
        w_idx       = w_idx_ext[IW-1:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_ready_set = 1'b0;
        w_do_write  = 1'b0;
        case (w_phase)
            SETUP: begin
                w_load      = 1'b1;
                w_cnt_nxt   = WS;
                w_ready_set = (WS == 4'd0);
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                if (r_pready) begin
                    w_do_write  = bus.i_psel && bus.i_penable && r_write && w_in_range;
                    w_state_nxt = IDLE;
                end else if (!bus.i_psel) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                    w_ready_set = (r_cnt == 4'd1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_prdata_nxt = (w_ready_set && !w_write_sel && w_in_range) ? r_mem[w_idx] : '0;
    end

    always_ff @(posedge pclk or negedge pnreset) begin
        if (!pnreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // pready/prdata are only ever high for the single completion cycle.
    always_ff @(posedge pclk or negedge pnreset) begin
        if (!pnreset) begin
            r_cnt    <= 4'd0;
            r_pready <= 1'b0;
            r_prdata <= '0;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_pready <= w_ready_set;
            r_prdata <= w_prdata_nxt;
            if (w_load) begin
                r_addr  <= bus.i_paddr;
                r_write <= bus.i_pwrite;
                r_wdata <= bus.i_pwdata;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (w_do_write) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign bus.o_pready = r_pready;
    assign bus.o_prdata = r_prdata;

`ifdef DMA_APB_SLV_PSLVERR_EN
    logic r_pslverr;

    always_ff @(posedge pclk or negedge pnreset) begin
        if (!pnreset) begin
            r_pslverr <= 1'b0;
        end else begin
            r_pslverr <= w_ready_set && !w_in_range;
        end
    end

    assign bus.o_pslverr = r_pslverr;
`else
    assign bus.o_pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_dma_apb_mem_slave.sv
// Self-checking bench for dma_apb_mem_slave: four instances with different wait states and
// base addresses share one driven bus, with psel steered to the instance under test.
module tb_dma_apb_mem_slave;
    localparam int NDUT = 4;
`ifdef DMA_APB_SLV_PSLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]  s;
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        bit          keep;
        bit          scr;
        logic [15:0] expD;
        logic        expE;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic        e;
        int          acc;
    } exp_t;

    logic        pclk    = 1'b0;
    logic        pnreset = 1'b0;
    logic [1:0]  sel     = 2'd0;
    logic        psel    = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [15:0] paddr   = 16'h0;
    logic [15:0] pwdata  = 16'h0;
    logic        rdyV [NDUT];
    logic [15:0] datV [NDUT];
    logic        errV [NDUT];
    logic        pready;
    logic        pslverr;
    logic [15:0] prdata;
    int          wsOf [NDUT] = '{1, 0, 3, 2};
    int          checks   = 0;
    int          failures = 0;
    exp_t        sb [$];
    vec_t        vecs [$];

    always #5 pclk = ~pclk;

    dma_apb_mem_slave_if #(.APB_ADDR_WIDTH(16), .APB_DATA_WIDTH(16)) if0 ();
    dma_apb_mem_slave_if #(.APB_ADDR_WIDTH(16), .APB_DATA_WIDTH(16)) if1 ();
    dma_apb_mem_slave_if #(.APB_ADDR_WIDTH(16), .APB_DATA_WIDTH(16)) if2 ();
    dma_apb_mem_slave_if #(.APB_ADDR_WIDTH(16), .APB_DATA_WIDTH(16)) if3 ();

    assign if0.i_psel = psel && (sel == 2'd0);
    assign if1.i_psel = psel && (sel == 2'd1);
    assign if2.i_psel = psel && (sel == 2'd2);
    assign if3.i_psel = psel && (sel == 2'd3);
    assign if0.i_penable = penable;
    assign if1.i_penable = penable;
    assign if2.i_penable = penable;
    assign if3.i_penable = penable;
    assign if0.i_pwrite = pwrite;
    assign if1.i_pwrite = pwrite;
    assign if2.i_pwrite = pwrite;
    assign if3.i_pwrite = pwrite;
    assign if0.i_paddr = paddr;
    assign if1.i_paddr = paddr;
    assign if2.i_paddr = paddr;
    assign if3.i_paddr = paddr;
    assign if0.i_pwdata = pwdata;
    assign if1.i_pwdata = pwdata;
    assign if2.i_pwdata = pwdata;
    assign if3.i_pwdata = pwdata;

    assign rdyV[0] = if0.o_pready;
    assign rdyV[1] = if1.o_pready;
    assign rdyV[2] = if2.o_pready;
    assign rdyV[3] = if3.o_pready;
    assign datV[0] = if0.o_prdata;
    assign datV[1] = if1.o_prdata;
    assign datV[2] = if2.o_prdata;
    assign datV[3] = if3.o_prdata;
    assign errV[0] = if0.o_pslverr;
    assign errV[1] = if1.o_pslverr;
    assign errV[2] = if2.o_pslverr;
    assign errV[3] = if3.o_pslverr;

    always_comb begin
        pready  = rdyV[sel];
        prdata  = datV[sel];
        pslverr = errV[sel];
    end

    dma_apb_mem_slave #(.APB_ADDR_WIDTH(16), .APB_DATA_WIDTH(16), .MEM_DEPTH(64),
                        .BASE_ADDR(0), .WAIT_STATES(1))
        u_dut0 (.pclk(pclk), .pnreset(pnreset), .bus(if0));
    dma_apb_mem_slave #(.APB_ADDR_WIDTH(16), .APB_DATA_WIDTH(16), .MEM_DEPTH(64),
                        .BASE_ADDR(0), .WAIT_STATES(0))
        u_dut1 (.pclk(pclk), .pnreset(pnreset), .bus(if1));
    dma_apb_mem_slave #(.APB_ADDR_WIDTH(16), .APB_DATA_WIDTH(16), .MEM_DEPTH(64),
                        .BASE_ADDR(0), .WAIT_STATES(3))
        u_dut2 (.pclk(pclk), .pnreset(pnreset), .bus(if2));
    dma_apb_mem_slave #(.APB_ADDR_WIDTH(16), .APB_DATA_WIDTH(16), .MEM_DEPTH(64),
                        .BASE_ADDR('h10), .WAIT_STATES(2))
        u_dut3 (.pclk(pclk), .pnreset(pnreset), .bus(if3));

    // Compares one observed value against its expectation and logs a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void addVec(input logic [1:0] s, input logic w, input logic [15:0] a,
                                   input logic [15:0] d, input bit keep, input bit scr,
                                   input logic [15:0] expD, input logic expE);
        vec_t v;
        v.s = s; v.w = w; v.a = a; v.d = d;
        v.keep = keep; v.scr = scr; v.expD = expD; v.expE = expE;
        vecs.push_back(v);
    endfunction

    // Runs one APB transfer starting just after a rising edge; the expectation goes onto the
    // scoreboard at drive time and is popped when the selected slave raises pready.
    task automatic applyStimulus(input logic [1:0] s, input logic w, input logic [15:0] a,
                                 input logic [15:0] d, input bit keep, input bit scr,
                                 input logic [15:0] expD, input logic expE);
        exp_t x;
        int   cyc;
        x.d = expD; x.e = expE; x.acc = wsOf[s] + 1;
        sb.push_back(x);
        sel = s; psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc = 1;
        while (pready !== 1'b1 && cyc <= 40) begin
            checkOutput("prdataWhileWaiting", 32'(prdata), 32'h0);
            if (scr && cyc == 1) begin
                paddr  = a ^ 16'h0001;
                pwdata = ~d;
            end
            @(posedge pclk); #1;
            cyc++;
        end
        if (pready !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL preadyTimeout: got no pready required pready within 40 cycles (addr 0x%0h)", a);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            x = sb.pop_front();
            checkOutput($sformatf("accessCycles[%0d:%0h]", s, a), 32'(cyc), 32'(x.acc));
            checkOutput($sformatf("prdata[%0d:%0h]", s, a), 32'(prdata), 32'(x.d));
            checkOutput($sformatf("pslverr[%0d:%0h]", s, a), 32'(pslverr), 32'(x.e));
        end
        @(posedge pclk); #1;
        checkOutput("preadyAfterCompletion", 32'(pready), 32'h0);
        checkOutput("prdataAfterCompletion", 32'(prdata), 32'h0);
        if (!keep) begin
            psel    = 1'b0;
            penable = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running required completion before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Single-transfer writes/reads, out-of-range aliasing, back-to-back, input scrambling.
        addVec(2'd0, 1'b1, 16'h0003, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0);
        addVec(2'd0, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b0);
        addVec(2'd0, 1'b1, 16'h0007, 16'h00FF, 1'b0, 1'b0, 16'h0000, 1'b0);
        addVec(2'd0, 1'b0, 16'h0007, 16'h0000, 1'b0, 1'b0, 16'h00FF, 1'b0);
        addVec(2'd0, 1'b1, 16'h0000, 16'h0A0A, 1'b0, 1'b0, 16'h0000, 1'b0);
        addVec(2'd0, 1'b1, 16'h0040, 16'hDEAD, 1'b0, 1'b0, 16'h0000, ERR_EN);
        addVec(2'd0, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0000, ERR_EN);
        addVec(2'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0A0A, 1'b0);
        addVec(2'd1, 1'b1, 16'h0000, 16'hA0A0, 1'b1, 1'b0, 16'h0000, 1'b0);
        addVec(2'd1, 1'b1, 16'h0001, 16'hA1A1, 1'b1, 1'b0, 16'h0000, 1'b0);
        addVec(2'd1, 1'b1, 16'h0002, 16'hA2A2, 1'b1, 1'b0, 16'h0000, 1'b0);
        addVec(2'd1, 1'b0, 16'h0002, 16'h0000, 1'b1, 1'b0, 16'hA2A2, 1'b0);
        addVec(2'd1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hA0A0, 1'b0);
        addVec(2'd1, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 16'hA1A1, 1'b0);
        addVec(2'd2, 1'b1, 16'h0005, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0);
        addVec(2'd2, 1'b1, 16'h0006, 16'h2222, 1'b0, 1'b1, 16'h0000, 1'b0);
        addVec(2'd2, 1'b0, 16'h0006, 16'h0000, 1'b0, 1'b1, 16'h2222, 1'b0);
        addVec(2'd3, 1'b1, 16'h0050, 16'h5555, 1'b0, 1'b0, 16'h0000, ERR_EN);
        addVec(2'd3, 1'b0, 16'h000F, 16'h0000, 1'b0, 1'b0, 16'h0000, ERR_EN);
        addVec(2'd3, 1'b1, 16'h0010, 16'h5A5A, 1'b0, 1'b0, 16'h0000, 1'b0);
        addVec(2'd3, 1'b1, 16'h004F, 16'hC3C3, 1'b0, 1'b0, 16'h0000, 1'b0);
        addVec(2'd3, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h5A5A, 1'b0);
        addVec(2'd3, 1'b0, 16'h004F, 16'h0000, 1'b0, 1'b0, 16'hC3C3, 1'b0);
        addVec(2'd3, 1'b0, 16'h0050, 16'h0000, 1'b0, 1'b0, 16'h0000, ERR_EN);

        pnreset = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("resetPready%0d", i), 32'(rdyV[i]), 32'h0);
            checkOutput($sformatf("resetPrdata%0d", i), 32'(datV[i]), 32'h0);
            checkOutput($sformatf("resetPslverr%0d", i), 32'(errV[i]), 32'h0);
        end
        pnreset = 1'b1;
        @(posedge pclk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].keep,
                          vecs[i].scr, vecs[i].expD, vecs[i].expE);
        end

        // Abort: psel drops in the second access cycle of a 3-wait-state write.
        sel = 2'd2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0005; pwdata = 16'hBEEF;
        @(posedge pclk); #1;
        penable = 1'b1;
        checkOutput("abortCycle1Pready", 32'(pready), 32'h0);
        @(posedge pclk); #1;
        checkOutput("abortCycle2Pready", 32'(pready), 32'h0);
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge pclk); #1;
            checkOutput("abortIdlePready", 32'(pready), 32'h0);
        end
        applyStimulus(2'd2, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h1111, 1'b0);

        // penable without a preceding setup phase must not start a transfer.
        sel = 2'd0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            checkOutput("noisePready", 32'(pready), 32'h0);
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;

        // Asynchronous reset while a read is completing.
        sel = 2'd0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0003;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        checkOutput("preResetPready", 32'(pready), 32'h1);
        checkOutput("preResetPrdata", 32'(prdata), 32'h1234);
        pnreset = 1'b0;
        #1;
        checkOutput("midResetPready", 32'(pready), 32'h0);
        checkOutput("midResetPrdata", 32'(prdata), 32'h0);
        checkOutput("midResetPslverr", 32'(pslverr), 32'h0);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        pnreset = 1'b1;
        @(posedge pclk); #1;
        checkOutput("postResetPready", 32'(pready), 32'h0);
        applyStimulus(2'd0, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b0);
        applyStimulus(2'd3, 1'b0, 16'h004F, 16'h0000, 1'b0, 1'b0, 16'hC3C3, 1'b0);

        checkOutput("scoreboardEmpty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
